// File: rtl/spi_ram_arbiter.sv
// spi_ram_arbiter: shares one SPI RAM controller between two bus masters.
// Each master's strobe is captured into a pending slot. Pending slots are
// granted round-robin and issued one at a time through the slave's
// strobe/busy handshake. A watchdog aborts a transaction the slave never
// finishes, returns ERR_DATA for an aborted read and latches a sticky err.
module spi_ram_arbiter #(
  parameter int          ADDR_W   = 20,
  parameter int          TIMEOUT  = 4096,
  parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] m0_word_address,
  input  logic [31:0]       m0_wdata,
  input  logic              m0_rd,
  input  logic              m0_wr,
  output logic [31:0]       m0_rdata,
  output logic              m0_rbusy,
  output logic              m0_wbusy,
  input  logic [ADDR_W-1:0] m1_word_address,
  input  logic [31:0]       m1_wdata,
  input  logic              m1_rd,
  input  logic              m1_wr,
  output logic [31:0]       m1_rdata,
  output logic              m1_rbusy,
  output logic              m1_wbusy,
  output logic [ADDR_W-1:0] s_word_address,
  output logic [31:0]       s_wdata,
  output logic              s_rd,
  output logic              s_wr,
  input  logic [31:0]       s_rdata,
  input  logic              s_rbusy,
  input  logic              s_wbusy,
  output logic              err
);

  localparam int CNT_W = $clog2(TIMEOUT) + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_e;

  state_e                     state_q, state_d;
  logic [1:0]                 v_q, v_d;          // slot valid
  logic [1:0]                 op_q, op_d;        // slot op, 1 = write
  logic [1:0][ADDR_W-1:0]     addr_q, addr_d;
  logic [1:0][31:0]           wdata_q, wdata_d;
  logic                       own_q, own_d;      // master owning the slave
  logic                       last_q, last_d;    // last granted master
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic [ADDR_W-1:0]          s_addr_q, s_addr_d;
  logic [31:0]                s_wdata_q, s_wdata_d;
  logic                       s_rd_q, s_rd_d;
  logic                       s_wr_q, s_wr_d;
  logic [1:0][31:0]           rdata_q, rdata_d;
  logic                       err_q, err_d;
  logic [1:0]                 rbusy_q, rbusy_d;
  logic [1:0]                 wbusy_q, wbusy_d;

  logic [1:0]                 strb_s;
  logic [1:0]                 wr_s;
  logic [1:0][ADDR_W-1:0]     in_addr_s;
  logic [1:0][31:0]           in_wdata_s;
  logic [1:0]                 clr_s;
  logic                       gsel_s;
  logic                       busy_s;

  assign strb_s     = {m1_rd | m1_wr, m0_rd | m0_wr};
  assign wr_s       = {m1_wr, m0_wr};   // rd and wr together counts as a write
  assign in_addr_s  = {m1_word_address, m0_word_address};
  assign in_wdata_s = {m1_wdata, m0_wdata};
  assign busy_s     = s_rbusy | s_wbusy;

  // Next-state logic: arbitration, issue/wait sequencing, watchdog and slot capture.
  always_comb begin
    state_d   = state_q;
    v_d       = v_q;
    op_d      = op_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    own_d     = own_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    s_addr_d  = s_addr_q;
    s_wdata_d = s_wdata_q;
    s_rd_d    = 1'b0;
    s_wr_d    = 1'b0;
    rdata_d   = rdata_q;
    err_d     = err_q;
    clr_s     = 2'b00;
    gsel_s    = 1'b0;

    case (state_q)
      IDLE: begin
        if (v_q != 2'b00) begin
          if (v_q == 2'b11) begin
            gsel_s = ~last_q;
          end else begin
            gsel_s = v_q[1];
          end
          own_d     = gsel_s;
          last_d    = gsel_s;
          s_addr_d  = addr_q[gsel_s];
          s_wdata_d = wdata_q[gsel_s];
          s_rd_d    = ~op_q[gsel_s];
          s_wr_d    = op_q[gsel_s];
          state_d   = ISSUE;
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        cnt_d   = {CNT_W{1'b0}};
        state_d = WAIT;
      end
      WAIT: begin
        // The first WAIT cycle never completes: the slave may not have raised busy yet.
        if ((cnt_q != {CNT_W{1'b0}}) && !busy_s) begin
          if (!op_q[own_q]) begin
            rdata_d[own_q] = s_rdata;
          end else begin
            rdata_d[own_q] = rdata_q[own_q];
          end
          clr_s[own_q] = 1'b1;
          state_d      = IDLE;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          if (!op_q[own_q]) begin
            rdata_d[own_q] = ERR_DATA;
          end else begin
            rdata_d[own_q] = rdata_q[own_q];
          end
          clr_s[own_q] = 1'b1;
          err_d        = 1'b1;
          state_d      = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // A strobe is accepted when the slot is empty or being freed at this edge.
    for (int i = 0; i < 2; i++) begin
      if (strb_s[i] && (!v_q[i] || clr_s[i])) begin
        v_d[i]     = 1'b1;
        op_d[i]    = wr_s[i];
        addr_d[i]  = in_addr_s[i];
        wdata_d[i] = in_wdata_s[i];
      end else if (clr_s[i]) begin
        v_d[i] = 1'b0;
      end else begin
        v_d[i] = v_q[i];
      end
    end

    rbusy_d = v_d & ~op_d;
    wbusy_d = v_d & op_d;
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      v_q       <= 2'b00;
      op_q      <= 2'b00;
      addr_q    <= '0;
      wdata_q   <= '0;
      own_q     <= 1'b0;
      last_q    <= 1'b1;
      cnt_q     <= {CNT_W{1'b0}};
      s_addr_q  <= {ADDR_W{1'b0}};
      s_wdata_q <= 32'h0;
      s_rd_q    <= 1'b0;
      s_wr_q    <= 1'b0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      rbusy_q   <= 2'b00;
      wbusy_q   <= 2'b00;
    end else begin
      state_q   <= state_d;
      v_q       <= v_d;
      op_q      <= op_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      own_q     <= own_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
      s_addr_q  <= s_addr_d;
      s_wdata_q <= s_wdata_d;
      s_rd_q    <= s_rd_d;
      s_wr_q    <= s_wr_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
      rbusy_q   <= rbusy_d;
      wbusy_q   <= wbusy_d;
    end
  end

  assign s_word_address = s_addr_q;
  assign s_wdata        = s_wdata_q;
  assign s_rd           = s_rd_q;
  assign s_wr           = s_wr_q;
  assign m0_rdata       = rdata_q[0];
  assign m1_rdata       = rdata_q[1];
  assign m0_rbusy       = rbusy_q[0];
  assign m1_rbusy       = rbusy_q[1];
  assign m0_wbusy       = wbusy_q[0];
  assign m1_wbusy       = wbusy_q[1];
  assign err            = err_q;

endmodule

// File: doc/spi_ram_arbiter.md
# spi_ram_arbiter

Two-master arbiter sharing the single memory-mapped SPI RAM controller between the FemtoRV32 CPU data port (master 0) and a second bus master such as a UART/DMA engine (master 1). The arbiter does four things:
- captures each master's one-cycle read/write strobe into a pending slot;
- grants the SPI RAM port round-robin;
- sequences exactly one transaction at a time through the slave's strobe/busy handshake;
- returns read data and busy status to the owning master.

A watchdog aborts transactions the slave never completes.

## Interface
Parameters:
- ADDR_W, 20, word-address width (matches word_address[21:2] of the SPI RAM controller)
- TIMEOUT, 4096, maximum cycles spent in WAIT before abort; must be ≥ 2
- ERR_DATA, 32'hDEADBEEF, rdata returned on an aborted read

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- m0_word_address  in  ADDR_W  master 0 word address, sampled on strobe
- m0_wdata  in  32  master 0 write data, sampled on strobe
- m0_rd  in  1  master 0 read strobe, one cycle
- m0_wr  in  1  master 0 write strobe, one cycle
- m0_rdata  out  32  master 0 read data, registered
- m0_rbusy  out  1  master 0 read outstanding
- m0_wbusy  out  1  master 0 write outstanding
- m1_word_address, m1_wdata, m1_rd, m1_wr, m1_rdata, m1_rbusy, m1_wbusy: identical to the m0 ports, for master 1
- s_word_address  out  ADDR_W  to SPI RAM controller, registered
- s_wdata  out  32  to SPI RAM controller, registered
- s_rd  out  1  read strobe to slave, one-cycle pulse
- s_wr  out  1  write strobe to slave, one-cycle pulse
- s_rdata  in  32  slave read data, valid when slave busy drops
- s_rbusy  in  1  slave read busy
- s_wbusy  in  1  slave write busy
- err  out  1  sticky timeout flag; cleared only by rst

## Operation
Pending slots (one per master: valid, op, addr, wdata):
- Strobe while the slot is empty: load the slot at that edge.
- m_rd and m_wr both high: treat as a write.
- Strobe while the slot is already valid: ignored (protocol violation); the slot is not overwritten.

Master busy outputs:
- mX_rbusy = slot valid and op = read.
- mX_wbusy = slot valid and op = write.

State machine:
- IDLE
  - No valid slot: stay.
  - Only one valid slot: grant that master.
  - Both valid: grant the master that was not granted last (last_grant register, reset to 1, so master 0 wins first).
  - On grant: load s_word_address/s_wdata from the granted slot, record the grant, go to ISSUE.
- ISSUE
  - Assert s_rd or s_wr for exactly this cycle.
  - Go to WAIT and clear the timeout counter.
- WAIT
  - Slave requirement: busy must be high by the first WAIT cycle.
  - Busy low (s_rbusy | s_wbusy = 0) on any WAIT cycle after the first: if the op was a read, mX_rdata ← s_rdata; clear the granted slot; go to IDLE.
  - Counter reaches TIMEOUT−1 with busy still high: abort. If the op was a read, mX_rdata ← ERR_DATA. Clear the slot, set err, go to IDLE.

Other rules:
- Master 1 strobes never affect master 0's slot, and vice versa.
- A master may re-strobe the cycle its busy drops.
- mX_rdata holds its last value until that master's next read completes; writes never change it.

## Timing
- Reset values:
  - state IDLE, both slots invalid, last_grant = 1
  - all busy outputs 0, s_rd = s_wr = 0
  - s_word_address = 0, s_wdata = 0, m0_rdata = m1_rdata = 0, err = 0
  - timeout counter 0
- Reset mid-transaction abandons it: no rdata update, slots cleared; the slave is reset by the same rst.
- Strobe at cycle T (arbiter idle, other slot empty):
  - mX_busy high at T+1
  - grant at the T+1 edge
  - s_rd/s_wr high during T+2
  - WAIT from T+3
- Slave busy first sampled low at WAIT cycle N: mX_busy low and mX_rdata valid at N+1.
- A new request is issued no earlier than the second cycle after the previous completion (IDLE cycle, then ISSUE).
- Strobe on the same cycle the arbiter clears that master's slot: accepted at that edge, because the slot is empty by then.
- Both masters strobe in the same cycle: both slots load; they are served back-to-back in round-robin order.

## Test plan
- Single read, master 0:
  - Stimulus: m0_rd, address 0x00010; slave holds busy 5 cycles returning 0x12345678.
  - Required: s_rd is a single pulse at T+2; m0_rbusy high from T+1 until the cycle after slave busy drops; then m0_rdata = 0x12345678.
- Simultaneous requests after reset:
  - Stimulus: m0 write to 0x4 and m1 read from 0x8 in the same cycle.
  - Required: master 0 is issued first, master 1 second; s_wr and s_rd never overlap.
- Round-robin fairness:
  - Stimulus: both masters re-strobe immediately on each completion, for 8 transactions.
  - Required: grants alternate 0,1,0,1,…
- Violation and isolation:
  - Stimulus: m1 strobes again while its slot is valid.
  - Required: the slot address is unchanged; m0_rdata is untouched by m1 reads.
- Timeout, with TIMEOUT = 16:
  - Stimulus: slave holds busy forever after an m0 read.
  - Required: abort at the 16th WAIT cycle; m0_rdata = 0xDEADBEEF; err = 1 and stays 1; the next request proceeds normally.
- Reset in WAIT:
  - Stimulus: assert rst for 1 cycle during WAIT.
  - Required: all outputs at reset values the next cycle; no rdata update.
